// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display controller.
//   state_t   : controller states (IDLE, SHOW_LO, SHOW_HI)
//   SEG_BLANK : active-low segment pattern with every segment off
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW_LO,
    SHOW_HI
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to 7-segment decoder.
//   nibble : 4-bit value 0..F
//   seg    : active-low segments {g,f,e,d,c,b,a}; lowercase glyphs for b and d
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Six-digit hex display controller with two-page paging for 32-bit values.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/ready/data : value handshake; accepted value is shown next cycle
//   blank_en      : leading-zero blanking enable (combinational)
//   hold          : freezes the page timer and state
//   page          : 1 while the high page (nibbles 7,6) is shown
//   hex0..hex5    : active-low segments, hex0 rightmost
// A value with a nonzero top byte is shown as a low page (nibbles 5..0)
// then a high page (nibbles 7..6), each for PAGE_CYCLES cycles. A new value
// is refused until one full low/high pass has completed.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned PAGE_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        blank_en,
  input  logic        hold,
  output logic        page,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int unsigned TW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [TW-1:0] TC = TW'(PAGE_CYCLES - 1);

  state_t          state, state_nx;
  logic [31:0]     value, value_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic            done, done_nx;

  logic            two_page;
  logic            accept;
  logic            tc;

  assign two_page = |value[31:24];
  assign in_ready = ~(two_page & ~done);
  assign accept   = in_valid & in_ready;
  assign tc       = (timer == TC);
  assign page     = (state == SHOW_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      value <= '0;
      timer <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      value <= value_nx;
      timer <= timer_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    value_nx = value;
    timer_nx = timer;
    done_nx  = done;
    if (accept) begin
      state_nx = SHOW_LO;
      value_nx = in_data;
      timer_nx = '0;
      done_nx  = 1'b0;
    end else if (!hold) begin
      unique case (state)
        SHOW_LO: begin
          if (two_page) begin
            if (tc) begin
              state_nx = SHOW_HI;
              timer_nx = '0;
            end else begin
              timer_nx = timer + TW'(1);
            end
          end
        end
        SHOW_HI: begin
          if (tc) begin
            state_nx = SHOW_LO;
            timer_nx = '0;
            done_nx  = 1'b1;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The two rightmost decoders are shared between pages: they take nibbles
  // 1,0 on the low page and nibbles 7,6 on the high page.
  logic [3:0] nib [6];
  logic [6:0] seg [6];

  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      nib[i] = value[4*i +: 4];
    end
    if (state == SHOW_HI) begin
      nib[0] = value[27:24];
      nib[1] = value[31:28];
    end
  end

  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g_dec
      hex_to_7seg u_dec (
        .nibble (nib[g]),
        .seg    (seg[g])
      );
    end
  endgenerate

  // lz[i]: nibbles i..5 are all zero, so digit i is a leading zero.
  logic [5:0] lz;
  logic       run;
  logic [6:0] disp [6];

  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int unsigned i = 5; i >= 1; i--) begin
      run   = run & (value[4*i +: 4] == 4'h0);
      lz[i] = run;
    end
    for (int unsigned i = 0; i < 6; i++) begin
      disp[i] = SEG_BLANK;
    end
    unique case (state)
      SHOW_LO: begin
        for (int unsigned i = 0; i < 6; i++) begin
          disp[i] = (blank_en && !two_page && lz[i]) ? SEG_BLANK : seg[i];
        end
      end
      SHOW_HI: begin
        disp[0] = seg[0];
        disp[1] = (blank_en && value[31:28] == 4'h0) ? SEG_BLANK : seg[1];
      end
      default: ;
    endcase
  end

  assign hex0 = disp[0];
  assign hex1 = disp[1];
  assign hex2 = disp[2];
  assign hex3 = disp[3];
  assign hex4 = disp[4];
  assign hex5 = disp[5];

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int unsigned P = 4;
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        blank_en = 1'b0;
  logic        hold = 1'b0;
  logic        page;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  always #5 clk = ~clk;

  hex_display_ctrl #(.PAGE_CYCLES(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .blank_en (blank_en),
    .hold     (hold),
    .page     (page),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = idle, 1 = low page, 2 = high page.
  logic [31:0] m_val  = '0;
  int          m_ph   = 0;
  int          m_cnt  = 0;
  logic        m_done = 1'b0;

  function automatic logic [41:0] hexes();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  function automatic logic [43:0] dut_out();
    return {in_ready, page, hexes()};
  endfunction

  function automatic logic m_two();
    return m_val[31:24] != 8'h00;
  endfunction

  function automatic logic [43:0] model_out();
    logic [6:0]  e [6];
    logic [31:0] sh;
    int          top;
    for (int i = 0; i < 6; i++) e[i] = BL;
    if (m_ph == 1) begin
      top = 0;
      for (int i = 0; i < 6; i++) begin
        sh = m_val >> (4 * i);
        if (sh[3:0] != 4'h0) top = i;
      end
      for (int i = 0; i < 6; i++) begin
        sh = m_val >> (4 * i);
        e[i] = (blank_en && !m_two() && i > top) ? BL : FONT[sh[3:0]];
      end
    end else if (m_ph == 2) begin
      e[0] = FONT[m_val[27:24]];
      e[1] = (blank_en && m_val[31:28] == 4'h0) ? BL : FONT[m_val[31:28]];
    end
    return {!(m_two() && !m_done), (m_ph == 2), e[5], e[4], e[3], e[2], e[1], e[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare every output against it shortly after the edge.
  task automatic tick();
    logic        r, v, h, rdy;
    logic [31:0] d;
    r = rst; v = in_valid; h = hold; d = in_data;
    rdy = !(m_two() && !m_done);
    @(posedge clk);
    if (r) begin
      m_val = '0; m_ph = 0; m_cnt = 0; m_done = 1'b0;
    end else if (v && rdy) begin
      m_val = d; m_ph = 1; m_cnt = 0; m_done = 1'b0;
    end else if (!h) begin
      if (m_ph == 1 && m_two()) begin
        if (m_cnt == int'(P) - 1) begin m_ph = 2; m_cnt = 0; end
        else m_cnt++;
      end else if (m_ph == 2) begin
        if (m_cnt == int'(P) - 1) begin m_ph = 1; m_cnt = 0; m_done = 1'b1; end
        else m_cnt++;
      end
    end
    #1;
    chk("model", 64'(dut_out()), 64'(model_out()));
  endtask

  task automatic accept(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] d;
    logic        b;
    logic [41:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{32'h00012AB3, 1'b1, {BL,    7'h79, 7'h24, 7'h08, 7'h03, 7'h30}};
    tbl[1] = '{32'h00000000, 1'b1, {BL,    BL,    BL,    BL,    BL,    7'h40}};
    tbl[2] = '{32'h00000000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[3] = '{32'h00FEDCBA, 1'b1, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};
    tbl[4] = '{32'h00000905, 1'b1, {BL,    BL,    BL,    7'h10, 7'h40, 7'h12}};
    tbl[5] = '{32'h00012AB3, 1'b0, {7'h40, 7'h79, 7'h24, 7'h08, 7'h03, 7'h30}};

    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk("reset", 64'(dut_out()), 64'({1'b1, 1'b0, {6{BL}}}));
    rst = 1'b0;

    // Single-page decode and blanking table
    for (int i = 0; i < 6; i++) begin
      blank_en = tbl[i].b;
      accept(tbl[i].d);
      chk("tbl_hex", 64'(hexes()), 64'(tbl[i].exp));
      chk("tbl_rdy_page", 64'({in_ready, page}), 64'(2'b10));
    end

    // Single page stays on page 0 with ready high
    blank_en = 1'b1;
    accept(32'h00012AB3);
    for (int i = 0; i < 20; i++) begin
      chk("single_hold", 64'({in_ready, page, hexes()}),
          64'({2'b10, BL, 7'h79, 7'h24, 7'h08, 7'h03, 7'h30}));
      tick();
    end

    // Two-page value: 4 cycles low, 4 cycles high, then ready again
    accept(32'h7F000001);
    for (int i = 0; i < 4; i++) begin
      chk("two_lo", 64'(dut_out()), 64'({2'b00, {5{7'h40}}, 7'h79}));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("two_hi", 64'(dut_out()), 64'({2'b01, {4{BL}}, 7'h78, 7'h0E}));
      tick();
    end
    chk("two_done", 64'({in_ready, page}), 64'(2'b10));

    // Hold in high page; nibble 7 zero blanks hex1
    accept(32'h0A000000);
    for (int i = 0; i < 5; i++) tick();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_hi", 64'(dut_out()), 64'({2'b01, {5{BL}}, 7'h08}));
    end
    hold = 1'b0;
    tick();
    tick();
    chk("hold_rem", 64'(page), 64'(1'b1));
    tick();
    chk("hold_end", 64'({in_ready, page}), 64'(2'b10));

    // Accept collides with low-page terminal count after done
    tick();
    tick();
    tick();
    chk("coll_pre", 64'(m_cnt), 64'(P - 1));
    accept(32'h00000005);
    chk("coll", 64'(dut_out()), 64'({2'b10, {5{BL}}, 7'h12}));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("coll_page", 64'(page), 64'(1'b0));
    end

    // Reset during high page with in_valid held high
    accept(32'h7F000001);
    for (int i = 0; i < 5; i++) tick();
    chk("rst_pre", 64'(page), 64'(1'b1));
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h12345678;
    tick();
    chk("rst_mid", 64'(dut_out()), 64'({2'b10, {6{BL}}}));
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_after", 64'(dut_out()), 64'({2'b10, {6{BL}}}));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = $urandom;
      if ($urandom_range(0, 1) == 0) in_data[31:24] = 8'h00;
      if ($urandom_range(0, 2) == 0) in_data[23:12] = 12'h000;
      blank_en = $urandom_range(0, 1) == 1;
      hold     = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 Parameter: PAGE_CYCLES, default 50_000_000, clock cycles per display page; legal range >= 2.
REQ-002 Port: clk  in  1  system clock; one clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: in_valid  in  1  producer offers in_data.
REQ-005 Port: in_ready  out  1  block can accept in_data.
REQ-006 Port: in_data  in  32  value to display, 8 hex nibbles.
REQ-007 Port: blank_en  in  1  leading-zero blanking enable, sampled combinationally.
REQ-008 Port: hold  in  1  freeze page timer.
REQ-009 Port: page  out  1  page currently shown: 0 = low, 1 = high.
REQ-010 Port: hex0..hex5  out  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 is rightmost; 7'b1111111 = blank.

Function
REQ-011 Transfer SHALL occur on any rising edge with in_valid=1 and in_ready=1; in_data is latched into a value register.
REQ-012 Digit outputs SHALL reflect the latched value from the first cycle after the accepting edge; this is 1-cycle latency, with decode combinational from registers.
REQ-013 A value is two-page when latched bits [31:24] != 0; otherwise it is single-page.
REQ-014 The FSM SHALL have states IDLE, SHOW_LO and SHOW_HI; page=1 only in SHOW_HI.
REQ-015 In IDLE, all digits are blank and in_ready=1; an accept goes to SHOW_LO with the timer cleared.
REQ-016 In SHOW_LO, hex5..hex0 show nibbles 5..0; with a single-page value the FSM stays in SHOW_LO indefinitely and the timer does not run.
REQ-017 In SHOW_LO with a two-page value, the timer counts 0..PAGE_CYCLES-1; at terminal count it moves to SHOW_HI with the timer cleared.
REQ-018 In SHOW_HI, hex1 shows nibble 7, hex0 shows nibble 6, and hex5..hex2 are blank.
REQ-019 In SHOW_HI, at terminal count the FSM moves to SHOW_LO with the timer cleared and sets the done flag.
REQ-020 in_ready SHALL be 0 while a two-page value is latched and done=0; it is 1 otherwise, including IDLE and single-page values.
REQ-021 Accepting a value clears done, clears the timer and forces SHOW_LO; accept has priority over terminal count in the same cycle.
REQ-022 hold=1 SHALL freeze the timer and state; it does not affect accept or in_ready.
REQ-023 Blanking in SHOW_LO with blank_en=1 blanks every digit above the highest nonzero nibble among nibbles 5..0; hex0 is never blanked, so value 0 shows "0".
REQ-024 Blanking in SHOW_HI with blank_en=1 blanks hex1 when nibble 7 = 0.
REQ-025 A two-page value in SHOW_LO SHALL show all of hex5..hex0 regardless of blank_en.
REQ-026 With blank_en=0, no digit is blanked except as specified in REQ-015 and REQ-018.
REQ-027 Timer width SHALL be $clog2(PAGE_CYCLES); the count never exceeds PAGE_CYCLES-1.

Reset
REQ-028 With rst=1 at an edge, state = IDLE, value register = 0, timer = 0, done = 0 and page = 0.
REQ-029 During and after reset, hex0..hex5 = 7'b1111111 and in_ready = 1.
REQ-030 Reset mid-page or mid-transfer SHALL discard the latched value and the in-flight transfer; rst has priority over accept.

Structure
REQ-031 The shared package hex_display_pkg SHALL hold the state enum and the constant SEG_BLANK = 7'b1111111.
REQ-032 Six instances of the existing sub-module hex_to_7seg SHALL decode the nibbles; the blanking mux sits after the decoders.
REQ-033 The FSM, timer and done flag SHALL live in hex_display_ctrl; no further sub-modules.

Verification (PAGE_CYCLES=4)
REQ-034 Reset: rst high 2 cycles -> all hex = 7'h7F, in_ready=1, page=0.
REQ-035 Single-page: accept 0x00012AB3 with blank_en=1 -> next cycle hex4..hex0 = 1,2,A,b,3; hex5 blank; in_ready stays 1; page stays 0 for 20 cycles.
REQ-036 Two-page: accept 0x7F000001 with blank_en=1 -> page 0 shows 000001 for 4 cycles; then page=1 with hex1=7, hex0=F for 4 cycles; then page=0 and in_ready=1; in_ready=0 throughout the preceding 8 cycles.
REQ-037 Hold: in the two-page case, assert hold for 10 cycles in SHOW_HI -> page stays 1 and the timer is frozen; on release, the remaining count completes.
REQ-038 Collision: accept 0x5 on the same edge as SHOW_LO terminal count after done -> SHOW_LO, hex0=5, page=0, no SHOW_HI entry.
REQ-039 Reset mid-operation: rst during SHOW_HI -> next cycle IDLE, all digits blank, in_ready=1; in_valid held high during rst is not accepted.
